apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus and register data width.
REQ-003 SHALL have parameter REG_CNT, default 8, number of word registers; valid range 1..2^(ADDR_W-2).
REQ-004 SHALL have parameter REG_MASK, default all ones, REG_CNT bits; bit i=1 means register i is implemented.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port psel, input, 1, APB select.
REQ-008 SHALL have port penable, input, 1, APB enable.
REQ-009 SHALL have port pwrite, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port paddr, input, ADDR_W, byte address.
REQ-011 SHALL have port pwdata, input, DATA_W, write data.
REQ-012 SHALL have port prdata, output, DATA_W, read data.
REQ-013 SHALL have port pready, output, 1, transfer complete.
REQ-014 SHALL have port pslverr, output, 1, error response.
REQ-015 SHALL have port reg_rd, output, REG_CNT, per-register one-cycle read strobe; drives a field's sw_rd.
REQ-016 SHALL have port reg_wr, output, REG_CNT, per-register one-cycle write strobe; drives a field's sw_wr.
REQ-017 SHALL have port reg_wr_data, output, DATA_W, write data; valid whenever any reg_wr bit is high.
REQ-018 SHALL have port reg_rd_data, input, REG_CNT*DATA_W, current register values, register i at bits [i*DATA_W +: DATA_W].

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, STROBE, RESP.
REQ-020 IDLE: psel=1 and penable=0 -> SETUP; latch paddr, pwrite and pwdata into internal registers.
REQ-021 SETUP: psel=1 and penable=1 -> STROBE; psel=0 -> IDLE, with no strobe issued.
REQ-022 STROBE lasts exactly one cycle, then -> RESP; in RESP pready=1 for exactly one cycle, then -> IDLE.
REQ-023 Decode: idx = latched paddr[ADDR_W-1:2]; an access is unmapped if paddr[1:0]!=0, idx>=REG_CNT, or REG_MASK[idx]=0.
REQ-024 STROBE, mapped write: reg_wr[idx]=1 and reg_wr_data = latched pwdata; every other strobe bit SHALL be 0.
REQ-025 STROBE, mapped read: reg_rd[idx]=1, and on the same clock edge prdata register <= reg_rd_data slice idx, so read-to-clear fields return their pre-clear value.
REQ-026 Unmapped access: no reg_rd or reg_wr bit asserted; in RESP, pslverr=1 and prdata=0.
REQ-027 Mapped write: prdata SHALL hold 0 in RESP.
REQ-028 Strobes SHALL be one-hot or zero and registered; at most one strobe per transfer.
REQ-029 Latency: setup cycle + 2 access cycles; pready is 0 in the first access cycle and 1 in the second.
REQ-030 pslverr and prdata SHALL be 0 in every state except RESP.
REQ-031 psel dropping in STROBE or RESP SHALL NOT cancel the strobe already issued; the FSM completes to IDLE.
REQ-032 penable=1 seen in IDLE (protocol violation) SHALL be ignored: no state change, no strobe.
REQ-033 Back-to-back transfers: a SETUP phase presented in the cycle after RESP SHALL be accepted from IDLE.
REQ-034 Writes issued while no transfer is active SHALL leave reg_wr_data unchanged (held at its last value).

Reset
REQ-035 While rst_n=0: state=IDLE; prdata=0, pready=0, pslverr=0, reg_rd=0, reg_wr=0, reg_wr_data=0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer immediately with no further strobes; the first transfer after reset starts from a fresh SETUP.

Verification
REQ-037 Write 0x04, data 0xA5A5A5A5 -> reg_wr=8'b0000_0010 for one cycle with reg_wr_data=0xA5A5A5A5; pready on the 2nd access cycle; pslverr=0.
REQ-038 Read 0x08 with reg 2 = 0x1234, where reg 2 clears on the edge reg_rd[2] is high -> prdata=0x1234 in RESP; reg_rd=8'b0000_0100 for exactly one cycle.
REQ-039 Read 0x21 (misaligned) and 0x40 (idx 16, out of range) with REG_CNT=8 -> no strobes; pslverr=1, prdata=0.
REQ-040 REG_MASK=8'hFD, write 0x04 -> no strobe, pslverr=1.
REQ-041 Back-to-back write 0x00 then read 0x00 -> read returns the newly written value; exactly two strobes total.
REQ-042 rst_n pulsed low during STROBE of a write -> all outputs 0 within the reset, no reg_wr after reset release; next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB register-slave front end: decodes an APB transfer into a single registered
// one-cycle read or write strobe for a bank of word registers.
module apb_reg_slave #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter int                 REG_CNT  = 8,
  parameter logic [REG_CNT-1:0] REG_MASK = '1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [REG_CNT-1:0]        reg_rd,
  output logic [REG_CNT-1:0]        reg_wr,
  output logic [DATA_W-1:0]         reg_wr_data,
  input  logic [REG_CNT*DATA_W-1:0] reg_rd_data
);
  localparam int IDX_W = ADDR_W - 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write;
  logic [DATA_W-1:0] a_wdata;

  logic [IDX_W-1:0]   a_idx;
  logic [REG_CNT-1:0] sel_oh;
  logic [DATA_W-1:0]  rd_sel;
  logic               mapped;

  assign a_idx = a_addr[ADDR_W-1:2];

  // Decode by loop so out-of-range indices never address reg_rd_data or REG_MASK.
  always_comb begin
    sel_oh = '0;
    rd_sel = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (a_idx == IDX_W'(i) && REG_MASK[i]) begin
        sel_oh[i] = 1'b1;
        rd_sel    = reg_rd_data[i*DATA_W +: DATA_W];
      end
    end
    mapped = (a_addr[1:0] == 2'b00) && (|sel_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_addr      <= '0;
      a_write     <= 1'b0;
      a_wdata     <= '0;
      prdata      <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      reg_rd      <= '0;
      reg_wr      <= '0;
      reg_wr_data <= '0;
    end else begin
      reg_rd  <= '0;
      reg_wr  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state   <= SETUP;
            a_addr  <= paddr;
            a_write <= pwrite;
            a_wdata <= pwdata;
          end
        end
        SETUP: begin
          if (!psel) begin
            state <= IDLE;
          end else if (penable) begin
            state <= STROBE;
            if (mapped) begin
              if (a_write) begin
                reg_wr      <= sel_oh;
                reg_wr_data <= a_wdata;
              end else begin
                reg_rd <= sel_oh;
              end
            end
          end
        end
        STROBE: begin
          // Sampled on the edge the read strobe is high: read-to-clear returns the old value.
          state   <= RESP;
          pready  <= 1'b1;
          pslverr <= !mapped;
          if (mapped && !a_write) prdata <= rd_sel;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: default instance plus a REG_MASK=8'hFD instance on a shared bus.
module tb_apb_reg_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic [31:0]  prdata, reg_wr_data;
  logic         pready, pslverr;
  logic [7:0]   reg_rd, reg_wr;
  logic [255:0] reg_rd_data;

  logic [31:0]  m_prdata, m_reg_wr_data;
  logic         m_pready, m_pslverr;
  logic [7:0]   m_reg_rd, m_reg_wr;
  logic [255:0] m_reg_rd_data;

  logic [31:0] regs [8];
  int total = 0;
  int bad   = 0;
  int n_strb = 0;
  int m_strb = 0;

  logic [31:0] p_rdy, s_wr, s_rd, s_wd, s_rdy, s_err, s_dat, r_rdy, r_err, r_dat, m_err;
  int          base, mbase;

  always #5 clk = ~clk;

  apb_reg_slave u_dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data)
  );

  apb_reg_slave #(.REG_MASK(8'hFD)) u_mask (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(m_prdata), .pready(m_pready), .pslverr(m_pslverr),
    .reg_rd(m_reg_rd), .reg_wr(m_reg_wr), .reg_wr_data(m_reg_wr_data), .reg_rd_data(m_reg_rd_data)
  );

  assign m_reg_rd_data = {8{32'hC0DE_0000}};

  // Register bank: writes land on the strobe edge, reg 2 clears when read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (reg_wr[i]) regs[i] <= reg_wr_data;
      if (reg_rd[2]) regs[2] <= '0;
    end
  end

  always_comb begin
    reg_rd_data = '0;
    for (int i = 0; i < 8; i++) reg_rd_data[i*32 +: 32] = regs[i];
  end

  always @(posedge clk) begin
    if (rst_n && (|reg_wr || |reg_rd)) n_strb++;
    if (rst_n && (|m_reg_wr || |m_reg_rd)) m_strb++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after an edge with the FSM idle; returns one cycle after RESP (idle again).
  task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    p_rdy = 32'(pready);
    @(posedge clk); #1;
    s_wr = 32'(reg_wr); s_rd = 32'(reg_rd); s_wd = reg_wr_data;
    s_rdy = 32'(pready); s_err = 32'(pslverr); s_dat = prdata;
    @(posedge clk); #1;
    r_rdy = 32'(pready); r_err = 32'(pslverr); r_dat = prdata; m_err = 32'(m_pslverr);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_strobes", 32'({reg_rd, reg_wr}), 32'h0);
    chk("rst_wr_data", reg_wr_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write 0x04
    base = n_strb; mbase = m_strb;
    xfer(8'h04, 1'b1, 32'hA5A5_A5A5);
    chk("wr04_pready_setup", p_rdy, 32'h0);
    chk("wr04_reg_wr", s_wr, 32'h2);
    chk("wr04_wr_data", s_wd, 32'hA5A5_A5A5);
    chk("wr04_pready_acc1", s_rdy, 32'h0);
    chk("wr04_idle_outs", s_err | s_dat, 32'h0);
    chk("wr04_pready_acc2", r_rdy, 32'h1);
    chk("wr04_pslverr", r_err, 32'h0);
    chk("wr04_prdata", r_dat, 32'h0);
    chk("wr04_strobe_cnt", 32'(n_strb - base), 32'h1);
    chk("wr04_pready_after", 32'(pready), 32'h0);
    chk("mask_wr04_err", m_err, 32'h1);
    chk("mask_wr04_nostrobe", 32'(m_strb - mbase), 32'h0);

    // Read-to-clear register 2
    xfer(8'h08, 1'b1, 32'h0000_1234);
    base = n_strb;
    xfer(8'h08, 1'b0, 32'hFFFF_FFFF);
    chk("rd08_reg_rd", s_rd, 32'h4);
    chk("rd08_reg_wr", s_wr, 32'h0);
    chk("rd08_wr_data_held", s_wd, 32'h0000_1234);
    chk("rd08_prdata_acc1", s_dat, 32'h0);
    chk("rd08_prdata", r_dat, 32'h0000_1234);
    chk("rd08_err", r_err, 32'h0);
    chk("rd08_strobe_cnt", 32'(n_strb - base), 32'h1);
    chk("rd08_prdata_after", prdata, 32'h0);
    xfer(8'h08, 1'b0, 32'h0);
    chk("rd08_cleared", r_dat, 32'h0);

    // Unmapped: misaligned and out of range
    base = n_strb;
    xfer(8'h21, 1'b0, 32'h0);
    chk("rd21_strobes", s_rd | s_wr, 32'h0);
    chk("rd21_err", r_err, 32'h1);
    chk("rd21_prdata", r_dat, 32'h0);
    xfer(8'h40, 1'b0, 32'h0);
    chk("rd40_err", r_err, 32'h1);
    chk("rd40_prdata", r_dat, 32'h0);
    xfer(8'h40, 1'b1, 32'h1111_1111);
    chk("wr40_err", r_err, 32'h1);
    chk("unmapped_strobe_cnt", 32'(n_strb - base), 32'h0);

    // Back-to-back write then read of 0x00
    base = n_strb;
    xfer(8'h00, 1'b1, 32'hDEAD_BEEF);
    chk("b2b_wr_strobe", s_wr, 32'h1);
    xfer(8'h00, 1'b0, 32'h0);
    chk("b2b_rd_strobe", s_rd, 32'h1);
    chk("b2b_rd_data", r_dat, 32'hDEAD_BEEF);
    chk("b2b_strobe_cnt", 32'(n_strb - base), 32'h2);

    // Protocol violation in IDLE, then an abandoned setup
    base = n_strb;
    psel = 1'b1; penable = 1'b1; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h5;
    repeat (2) @(posedge clk);
    #1;
    chk("viol_pready", 32'(pready), 32'h0);
    penable = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("viol_abort_strobes", 32'(n_strb - base), 32'h0);
    chk("viol_pready_end", 32'(pready), 32'h0);

    // Reset during STROBE of a write
    base = n_strb;
    psel = 1'b1; penable = 1'b0; paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'h55;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_strobe_seen", 32'(reg_wr), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_reg_wr", 32'(reg_wr), 32'h0);
    chk("rst_mid_wr_data", reg_wr_data, 32'h0);
    chk("rst_mid_pready", 32'(pready), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_strobe", 32'(n_strb - base), 32'h0);
    xfer(8'h0C, 1'b1, 32'h77);
    chk("post_rst_wr", s_wr, 32'h8);
    chk("post_rst_rdy", r_rdy, 32'h1);
    xfer(8'h0C, 1'b0, 32'h0);
    chk("post_rst_rd", r_dat, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
